// File: rtl/sram_arbiter_if.sv
// Request/response bundle between the recorder/DSP clients and the SRAM arbiter.
// master = client side (issues requests), slave = arbiter side.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        input  o_wr_ack, o_rd_valid, o_rd_data
    );

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        output o_wr_ack, o_rd_valid, o_rd_data
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between a recorder (writes) and a DSP (reads),
// tracking the record-end pointer so reads past recorded data return zero without an access.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_AUD_BCLK,
    input  logic              i_rst_n,
    sram_arbiter_if.slave     bus,
    input  logic              i_clear,
    output logic [ADDR_W-1:0] o_rec_end,
    output logic              o_full,
    output logic              o_overrun,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_SETUP = 3'd1;
    localparam logic [2:0] WR_PULSE = 3'd2;
    localparam logic [2:0] WR_HOLD  = 3'd3;
    localparam logic [2:0] RD_ADDR  = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ZERO  = 3'd6;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              last_rd_q, last_rd_d;
    logic [ADDR_W-1:0] wr_pend_addr_q, wr_pend_addr_d;
    logic [DATA_W-1:0] wr_pend_data_q, wr_pend_data_d;
    logic [ADDR_W-1:0] rd_pend_addr_q, rd_pend_addr_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_data_q, acc_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rec_end_q, rec_end_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              ce_n_q, ce_n_d;

    logic              grant_wr;
    logic              grant_rd;
    logic              dq_oe;
    logic [ADDR_W-1:0] wr_end;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == IDLE) begin
            if (wr_pend_q && (!rd_pend_q || last_rd_q)) begin
                grant_wr = 1'b1;
            end else if (rd_pend_q) begin
                grant_rd = 1'b1;
            end
        end
    end

    // A pulse landing on the cycle its pending request is granted loses nothing,
    // since the granted address/data are copied into the access registers.
    always_comb begin
        wr_pend_d      = wr_pend_q & ~grant_wr;
        wr_pend_addr_d = wr_pend_addr_q;
        wr_pend_data_d = wr_pend_data_q;
        rd_pend_d      = rd_pend_q & ~grant_rd;
        rd_pend_addr_d = rd_pend_addr_q;
        if (bus.i_wr_req) begin
            wr_pend_d      = 1'b1;
            wr_pend_addr_d = bus.i_wr_addr;
            wr_pend_data_d = bus.i_wr_data;
        end
        if (bus.i_rd_req) begin
            rd_pend_d      = 1'b1;
            rd_pend_addr_d = bus.i_rd_addr;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        acc_addr_d = acc_addr_q;
        acc_data_d = acc_data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d    = WR_SETUP;
                    last_rd_d  = 1'b0;
                    acc_addr_d = wr_pend_addr_q;
                    acc_data_d = wr_pend_data_q;
                end else if (grant_rd) begin
                    last_rd_d = 1'b1;
                    if (rd_pend_addr_q < rec_end_q) begin
                        state_d    = RD_ADDR;
                        acc_addr_d = rd_pend_addr_q;
                    end else begin
                        state_d = RD_ZERO;
                    end
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            RD_ADDR:  state_d = RD_DATA;
            RD_DATA: begin
                state_d    = IDLE;
                rd_valid_d = 1'b1;
                rd_data_d  = io_SRAM_DQ;
            end
            RD_ZERO: begin
                state_d    = IDLE;
                rd_valid_d = 1'b1;
                rd_data_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Top address saturates the end pointer instead of wrapping to zero.
    assign wr_end = (acc_addr_q == ADDR_MAX) ? ADDR_MAX : acc_addr_q + 1'b1;

    always_comb begin
        rec_end_d = rec_end_q;
        full_d    = full_q;
        overrun_d = overrun_q
                  | (bus.i_wr_req & wr_pend_q & ~grant_wr)
                  | (bus.i_rd_req & rd_pend_q & ~grant_rd);
        ce_n_d    = 1'b0;
        if (state_q == WR_HOLD) begin
            if (wr_end > rec_end_q) begin
                rec_end_d = wr_end;
            end
            if (acc_addr_q == ADDR_MAX) begin
                full_d = 1'b1;
            end
        end
        if (i_clear) begin
            rec_end_d = '0;
            full_d    = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_AUD_BCLK or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q        <= IDLE;
            wr_pend_q      <= 1'b0;
            rd_pend_q      <= 1'b0;
            last_rd_q      <= 1'b1;
            wr_pend_addr_q <= '0;
            wr_pend_data_q <= '0;
            rd_pend_addr_q <= '0;
            acc_addr_q     <= '0;
            acc_data_q     <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rec_end_q      <= '0;
            full_q         <= 1'b0;
            overrun_q      <= 1'b0;
            ce_n_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            wr_pend_q      <= wr_pend_d;
            rd_pend_q      <= rd_pend_d;
            last_rd_q      <= last_rd_d;
            wr_pend_addr_q <= wr_pend_addr_d;
            wr_pend_data_q <= wr_pend_data_d;
            rd_pend_addr_q <= rd_pend_addr_d;
            acc_addr_q     <= acc_addr_d;
            acc_data_q     <= acc_data_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            rec_end_q      <= rec_end_d;
            full_q         <= full_d;
            overrun_q      <= overrun_d;
            ce_n_q         <= ce_n_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them in the same cycle.
    assign dq_oe       = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
    assign io_SRAM_DQ  = dq_oe ? acc_data_q : 'z;
    assign o_SRAM_ADDR = acc_addr_q;
    assign o_SRAM_WE_N = (state_q != WR_PULSE);
    assign o_SRAM_OE_N = !((state_q == RD_ADDR) || (state_q == RD_DATA));
    assign o_SRAM_CE_N = ce_n_q;
    assign o_SRAM_LB_N = ce_n_q;
    assign o_SRAM_UB_N = ce_n_q;

    assign bus.o_wr_ack   = (state_q == WR_HOLD);
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_rd_data  = rd_data_q;
    assign o_rec_end      = rec_end_q;
    assign o_full         = full_q;
    assign o_overrun      = overrun_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural async SRAM model.
module tb_sram_arbiter;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          clear = 1'b0;
    logic [AW-1:0] rec_end;
    logic [AW-1:0] sram_addr;
    logic          full, overrun, we_n, oe_n, ce_n, lb_n, ub_n;
    wire  [DW-1:0] sram_dq;
    logic [DW-1:0] mem [256];

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   cyc      = 0;
    int unsigned   we_lo_n, we_lo_cyc, ack_n, ack_cyc, oe_lo_n, rv_n, rv_cyc;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_dq, rv_data;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_AUD_BCLK  (clk),
        .i_rst_n     (rst),
        .bus         (bus),
        .i_clear     (clear),
        .o_rec_end   (rec_end),
        .o_full      (full),
        .o_overrun   (overrun),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (sram_dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    // SRAM model: low address byte only, enough for the directed addresses used here.
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 'z;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        we_lo_n = 0; we_lo_cyc = 0; ack_n = 0; ack_cyc = 0;
        oe_lo_n = 0; rv_n = 0; rv_cyc = 0;
        we_addr = '0; we_dq = '0; rv_data = '0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!we_n) begin
            we_lo_n++; we_lo_cyc = cyc; we_addr = sram_addr; we_dq = sram_dq;
        end
        if (bus.o_wr_ack) begin
            ack_n++; ack_cyc = cyc;
        end
        if (!oe_n) oe_lo_n++;
        if (bus.o_rd_valid) begin
            rv_n++; rv_cyc = cyc; rv_data = bus.o_rd_data;
        end
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_wr_req = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
        step();
        bus.i_wr_req = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.i_rd_req = 1'b1; bus.i_rd_addr = a;
        step();
        bus.i_rd_req = 1'b0;
    endtask

    task automatic wr_rd(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        bus.i_wr_req = 1'b1; bus.i_wr_addr = wa; bus.i_wr_data = wd;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = ra;
        step();
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
    endtask

    initial begin
        int unsigned c;
        bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
        clr_mon();
        steps(3);
        check("rst_wr_ack",   bus.o_wr_ack,   0);
        check("rst_rd_valid", bus.o_rd_valid, 0);
        check("rst_rd_data",  bus.o_rd_data,  0);
        check("rst_rec_end",  rec_end,  0);
        check("rst_full",     full,     0);
        check("rst_overrun",  overrun,  0);
        check("rst_we_n",     we_n,     1);
        check("rst_oe_n",     oe_n,     1);
        check("rst_ce_n",     ce_n,     1);
        check("rst_addr",     sram_addr, 0);
        rst = 1'b0;
        steps(2);
        check("run_ce_n", ce_n, 0);
        check("run_lb_ub", {lb_n, ub_n}, 0);

        // Basic write
        clr_mon(); c = cyc;
        wr(20'd5, 16'h1234); steps(5);
        check("wr_we_lo_count", we_lo_n, 1);
        check("wr_we_lo_cycle", we_lo_cyc, c + 3);
        check("wr_we_addr",     we_addr, 5);
        check("wr_we_dq",       we_dq, 16'h1234);
        check("wr_ack_count",   ack_n, 1);
        check("wr_ack_cycle",   ack_cyc, c + 4);
        check("wr_rec_end",     rec_end, 6);

        // Read inside and past the recorded range
        clr_mon(); c = cyc;
        rd(20'd5); steps(5);
        check("rd_valid_count", rv_n, 1);
        check("rd_valid_cycle", rv_cyc, c + 4);
        check("rd_data",        rv_data, 16'h1234);
        check("rd_oe_cycles",   oe_lo_n, 2);
        clr_mon(); c = cyc;
        rd(20'd6); steps(4);
        check("rz_valid_cycle", rv_cyc, c + 3);
        check("rz_data",        rv_data, 0);
        check("rz_oe_cycles",   oe_lo_n, 0);
        check("rz_data_held",   bus.o_rd_data, 0);

        // Two writes during a read: second overwrites the first
        clr_mon(); c = cyc;
        rd(20'd5); step();
        wr(20'd20, 16'hAAAA);
        wr(20'd21, 16'hBBBB);
        steps(8);
        check("ov_flag",      overrun, 1);
        check("ov_rd_cycle",  rv_cyc, c + 4);
        check("ov_rd_data",   rv_data, 16'h1234);
        check("ov_we_count",  we_lo_n, 1);
        check("ov_we_addr",   we_addr, 21);
        check("ov_we_dq",     we_dq, 16'hBBBB);
        check("ov_ack_cycle", ack_cyc, c + 7);
        check("ov_rec_end",   rec_end, 22);

        clear = 1'b1; step(); clear = 1'b0; step();
        check("clr_overrun", overrun, 0);
        check("clr_rec_end", rec_end, 0);

        // Top address saturates and sets full
        clr_mon();
        wr(20'hFFFFF, 16'h5555); steps(5);
        check("full_flag",    full, 1);
        check("full_rec_end", rec_end, 20'hFFFFF);
        check("full_we_addr", we_addr, 20'hFFFFF);

        // Clear coinciding with WR_HOLD wins
        clr_mon(); c = cyc;
        wr(20'd3, 16'h0303); steps(3);
        clear = 1'b1; step(); clear = 1'b0;
        steps(2);
        check("hclr_ack_cycle", ack_cyc, c + 4);
        check("hclr_ack_count", ack_n, 1);
        check("hclr_rec_end",   rec_end, 0);
        check("hclr_full",      full, 0);

        // Reset mid write pulse
        clr_mon(); c = cyc;
        wr(20'd7, 16'h0707); steps(2);
        check("arst_pulse_we", we_n, 0);
        rst = 1'b1; #1;
        check("arst_we_n", we_n, 1);
        check("arst_ce_n", ce_n, 1);
        check("arst_addr", sram_addr, 0);
        steps(4);
        check("arst_no_ack",   ack_n, 0);
        check("arst_no_valid", rv_n, 0);
        check("arst_rd_data",  bus.o_rd_data, 0);
        check("arst_oe_n",     oe_n, 1);
        rst = 1'b0;
        steps(2);

        // Simultaneous requests after reset: write first, twice
        clr_mon(); c = cyc;
        wr_rd(20'd9, 16'hBEEF, 20'd9); steps(9);
        check("tie1_ack_cycle", ack_cyc, c + 4);
        check("tie1_rd_cycle",  rv_cyc, c + 8);
        check("tie1_rd_data",   rv_data, 16'hBEEF);
        clr_mon(); c = cyc;
        wr_rd(20'd9, 16'hCAFE, 20'd9); steps(9);
        check("tie2_ack_cycle", ack_cyc, c + 4);
        check("tie2_rd_cycle",  rv_cyc, c + 8);
        check("tie2_rd_data",   rv_data, 16'hCAFE);

        clr_mon(); c = cyc;
        rd(20'd9); steps(5);
        check("lone_rd_cycle", rv_cyc, c + 4);
        check("lone_rd_data",  rv_data, 16'hCAFE);
        clr_mon();
        wr(20'd3, 16'h1111); steps(5);
        check("lone_wr_ack", ack_n, 1);

        // Last grant was a write, so the read wins this tie
        clr_mon(); c = cyc;
        wr_rd(20'd9, 16'hD00D, 20'd9); steps(9);
        check("tie3_rd_cycle",  rv_cyc, c + 4);
        check("tie3_rd_data",   rv_data, 16'hCAFE);
        check("tie3_ack_cycle", ack_cyc, c + 7);
        check("tie3_we_dq",     we_dq, 16'hD00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have port i_AUD_BCLK  input  1  clock; all logic rising-edge on it.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-high (block held in reset while i_rst_n=1).
REQ-005 SHALL have port i_wr_req  input  1  one-cycle pulse: recorder write request.
REQ-006 SHALL have ports i_wr_addr  input  ADDR_W  and  i_wr_data  input  DATA_W, both sampled on the i_wr_req cycle.
REQ-007 SHALL have port o_wr_ack  output  1  one-cycle pulse: write completed.
REQ-008 SHALL have port i_rd_req  input  1  one-cycle pulse: DSP read request; port i_rd_addr  input  ADDR_W  sampled on the i_rd_req cycle.
REQ-009 SHALL have ports o_rd_valid  output  1  one-cycle pulse, and o_rd_data  output  DATA_W  read result, held until the next o_rd_valid.
REQ-010 SHALL have port i_clear  input  1  one-cycle pulse: clear the record-end pointer and flags.
REQ-011 SHALL have ports o_rec_end  output  ADDR_W  (one past the highest written address), o_full  output  1, and o_overrun  output  1.
REQ-012 SHALL have SRAM ports o_SRAM_ADDR  output  ADDR_W;  io_SRAM_DQ  inout  DATA_W;  o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_CE_N, o_SRAM_LB_N, o_SRAM_UB_N  output  1 each.

Function
REQ-013 SHALL latch each request pulse into a pending flag (wr_pend, rd_pend) with its address/data; the flag SHALL clear when that request is granted.
REQ-014 SHALL set sticky o_overrun when a request pulse arrives while its own pending flag is set; the new request SHALL overwrite the pending address/data.
REQ-015 SHALL use the FSM states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_DATA and RD_ZERO.
REQ-016 SHALL, in IDLE with exactly one pending request, grant it; with both pending, grant the port not granted last (round-robin); last-grant SHALL be "read" after reset, so write wins the first tie.
REQ-017 SHALL sequence a write grant as IDLE->WR_SETUP->WR_PULSE->WR_HOLD->IDLE.
REQ-018 During a write, o_SRAM_ADDR and io_SRAM_DQ SHALL be driven in all three write states.
REQ-019 During a write, o_SRAM_WE_N SHALL be 0 only in WR_PULSE.
REQ-020 During a write, o_wr_ack SHALL pulse in WR_HOLD, 3 cycles after the grant.
REQ-021 SHALL sequence a read grant with rd_addr < o_rec_end as IDLE->RD_ADDR->RD_DATA->IDLE: o_SRAM_OE_N=0 in both states, io_SRAM_DQ high-Z, and the DQ value sampled at the end of RD_DATA.
REQ-022 On that read, o_rd_valid SHALL pulse with o_rd_data set during the first IDLE cycle after RD_DATA.
REQ-023 SHALL, for a read with rd_addr >= o_rec_end, go IDLE->RD_ZERO->IDLE with no SRAM access, o_rd_data=0, and o_rd_valid pulsing in the cycle after RD_ZERO.
REQ-024 SHALL drive io_SRAM_DQ only in write states; otherwise high-Z.
REQ-025 SHALL hold o_SRAM_WE_N=1 and o_SRAM_OE_N=1 in IDLE and RD_ZERO.
REQ-026 SHALL tie o_SRAM_CE_N, o_SRAM_LB_N and o_SRAM_UB_N to 0 out of reset.
REQ-027 SHALL update o_rec_end := max(o_rec_end, wr_addr+1) at WR_HOLD.
REQ-028 When wr_addr = 2^ADDR_W-1, o_rec_end SHALL saturate at 2^ADDR_W-1 and sticky o_full SHALL set; it SHALL never wrap to 0.
REQ-029 SHALL, on i_clear, set o_rec_end=0, o_full=0, o_overrun=0; an in-flight access SHALL still complete.
REQ-030 If i_clear coincides with WR_HOLD, clear SHALL win (o_rec_end=0 afterwards).
REQ-031 A read's end-pointer compare SHALL use o_rec_end as registered at grant time.
REQ-032 Request pulses arriving in any state SHALL be captured; none SHALL be lost except by the overwrite rule of REQ-014.

Reset
REQ-033 SHALL, while i_rst_n=1, force state IDLE; pending flags 0; last-grant=read.
REQ-034 While i_rst_n=1, SRAM strobes SHALL be inactive: WE_N=1, OE_N=1, CE_N=1, DQ high-Z, o_SRAM_ADDR=0.
REQ-035 While i_rst_n=1, outputs SHALL be o_wr_ack=0, o_rd_valid=0, o_rd_data=0, o_rec_end=0, o_full=0, o_overrun=0.
REQ-036 Reset asserted mid-access SHALL abort immediately; no ack or valid SHALL be issued for the aborted access.

Verification
REQ-037 Write 0x1234 to addr 5 -> WE_N low exactly one cycle, o_wr_ack 3 cycles after grant, o_rec_end=6.
REQ-038 Read addr 5 after REQ-037 (SRAM model returns 0x1234) -> o_rd_valid 3 cycles after grant with o_rd_data=0x1234; read addr 6 -> o_rd_data=0 with no OE_N assertion.
REQ-039 Simultaneous wr_req and rd_req pulses after reset -> write served first, then read; repeat the pair -> write first again; lone reads alternate correctly with writes.
REQ-040 Two wr_req pulses 1 cycle apart while a read is in progress -> o_overrun=1, only the second write's data appears in SRAM.
REQ-041 Write to addr 0xFFFFF -> o_full=1, o_rec_end=0xFFFFF; i_clear during WR_HOLD of a write -> o_rec_end=0, o_full=0 afterwards.
REQ-042 i_rst_n raised during WR_PULSE -> WE_N=1 and DQ high-Z in the same cycle, no o_wr_ack, all outputs at reset values.
